serial_converter: RTL and testbench

//  Receive-side inverse of the lane distributor. Takes one full set of N_LANES coded blocks
//  (one block per lane, presented in parallel) and re-serialises it into a single block stream,

---
 rtl/serial_converter.sv | 76 +++++++
 tb/tb_serial_converter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_converter.sv
// serial_converter: re-serialises one parallel set of N_LANES coded blocks into a block stream, lane 0 first
module serial_converter #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES = 20,
  localparam int CW = $clog2(N_LANES),
  localparam int SW = N_LANES * LEN_CODED_BLOCK
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic [SW-1:0]              i_lanes,
  input  logic                       i_enable,
  output logic                       o_ready,
  output logic [LEN_CODED_BLOCK-1:0] o_block,
  output logic                       o_valid,
  output logic [CW-1:0]              o_lane_idx,
  output logic                       o_sof,
  output logic                       o_overflow
);
  localparam logic [CW-1:0] LAST = CW'(N_LANES - 1);
  logic [SW-1:0] act_q, act_d, pend_q, pend_d;
  logic act_full_q, act_full_d, pend_full_q, pend_full_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [LEN_CODED_BLOCK-1:0] blk_q, blk_d;
  logic vld_q, vld_d, sof_q, sof_d, ovf_q, ovf_d;
  logic emit, last, load, to_act;
  // A new set goes straight to active whenever active is (or is about to be) free; pending is promoted first
  always_comb begin
    emit        = act_full_q && i_enable;
    last        = emit && cnt_q == LAST;
    load        = i_valid && !pend_full_q;
    to_act      = load && (!act_full_q || (last && !pend_full_q));
    act_d       = to_act ? i_lanes : (last && pend_full_q) ? pend_q : act_q;
    pend_d      = (load && !to_act) ? i_lanes : pend_q;
    act_full_d  = to_act || (act_full_q && !(last && !pend_full_q));
    pend_full_d = (load && !to_act) || (pend_full_q && !last);
    cnt_d       = !emit ? cnt_q : last ? '0 : cnt_q + 1'b1;
    blk_d       = emit ? act_q[int'(cnt_q) * LEN_CODED_BLOCK +: LEN_CODED_BLOCK] : blk_q;
    idx_d       = emit ? cnt_q : idx_q;
    sof_d       = emit ? (cnt_q == '0) : sof_q;
    vld_d       = emit;
    ovf_d       = ovf_q || (i_valid && pend_full_q);
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      act_full_q  <= 1'b0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      blk_q       <= '0;
      idx_q       <= '0;
      sof_q       <= 1'b0;
      vld_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      act_full_q  <= act_full_d;
      pend_full_q <= pend_full_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      idx_q       <= idx_d;
      sof_q       <= sof_d;
      vld_q       <= vld_d;
      ovf_q       <= ovf_d;
    end
  end
  // Buffer contents are only meaningful under their full flags, so they carry no reset
  always_ff @(posedge i_clock) begin
    act_q  <= act_d;
    pend_q <= pend_d;
  end
  assign o_ready    = !pend_full_q;
  assign o_block    = blk_q;
  assign o_valid    = vld_q;
  assign o_lane_idx = idx_q;
  assign o_sof      = sof_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_serial_converter.sv
// tb_serial_converter: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_serial_converter;
  localparam int L = 66;
  localparam int N = 20;
  typedef struct packed {
    logic [L-1:0] blk;
    logic [4:0]   idx;
    logic         sof;
  } exp_t;
  logic i_clock, i_reset, i_valid, i_enable;
  logic [N*L-1:0] i_lanes;
  logic o_ready, o_valid, o_sof, o_overflow;
  logic [L-1:0] o_block;
  logic [4:0] o_lane_idx;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  serial_converter #(.LEN_CODED_BLOCK(L), .N_LANES(N)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_lanes(i_lanes),
    .i_enable(i_enable), .o_ready(o_ready), .o_block(o_block), .o_valid(o_valid),
    .o_lane_idx(o_lane_idx), .o_sof(o_sof), .o_overflow(o_overflow)
  );
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge i_clock) begin
    if (o_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL stream_extra: got blk=%0h lane=%0d sof=%0b expected no output", o_block, o_lane_idx, o_sof);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({o_block, o_lane_idx, o_sof} !== e) begin
          failures++;
          $display("FAIL stream: got blk=%0h lane=%0d sof=%0b expected blk=%0h lane=%0d sof=%0b",
                   o_block, o_lane_idx, o_sof, e.blk, e.idx, e.sof);
        end
      end
    end
  end
  task automatic load_set(input int base);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(posedge i_clock); #1;
      n++;
    end
    chk("load_ready", 72'(o_ready), 72'(1));
    for (int k = 0; k < N; k++) begin
      i_lanes[k*L +: L] = L'(base + k);
      sb.push_back({L'(base + k), 5'(k), k == 0});
    end
    i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge i_clock);
      n++;
    end
    chk(name, 72'(sb.size()), 72'(0));
    @(negedge i_clock);
    chk({name, "_idle"}, 72'(o_valid), 72'(0));
  endtask
  initial begin
    int cnt;
    i_reset = 1'b0; i_valid = 1'b1; i_enable = 1'b1; i_lanes = '1;
    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_valid", 72'(o_valid), 72'(0));
    chk("rst_block", 72'(o_block), 72'(0));
    chk("rst_lane", 72'(o_lane_idx), 72'(0));
    chk("rst_sof", 72'(o_sof), 72'(0));
    chk("rst_ovf", 72'(o_overflow), 72'(0));
    chk("rst_ready", 72'(o_ready), 72'(1));
    i_valid = 1'b0; i_reset = 1'b1;
    @(posedge i_clock); #1;
    load_set(1);
    @(negedge i_clock);
    chk("lat_early", 72'(o_valid), 72'(0));
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge i_clock);
      cnt += int'(o_valid);
    end
    chk("single_run", 72'(cnt), 72'(N));
    @(negedge i_clock);
    chk("single_end", 72'(o_valid), 72'(0));
    chk("single_sb", 72'(sb.size()), 72'(0));
    @(posedge i_clock); #1;
    load_set(100);
    load_set(200);
    chk("b2b_ready_lo", 72'(o_ready), 72'(0));
    cnt = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge i_clock);
      cnt += int'(o_valid);
      if (i == 18) chk("b2b_ready_held", 72'(o_ready), 72'(0));
      if (i == 19) chk("b2b_ready_promo", 72'(o_ready), 72'(1));
    end
    chk("b2b_run", 72'(cnt), 72'(2 * N));
    @(negedge i_clock);
    chk("b2b_end", 72'(o_valid), 72'(0));
    chk("b2b_sb", 72'(sb.size()), 72'(0));
    chk("ovf_clear", 72'(o_overflow), 72'(0));
    @(posedge i_clock); #1;
    load_set(300);
    load_set(400);
    for (int k = 0; k < N; k++) i_lanes[k*L +: L] = L'(500 + k);
    i_valid = 1'b1;
    @(posedge i_clock); #1;
    i_valid = 1'b0;
    chk("ovf_set", 72'(o_overflow), 72'(1));
    wait_drain("ovf_drain");
    chk("ovf_sticky", 72'(o_overflow), 72'(1));
    @(posedge i_clock); #1;
    i_enable = 1'b0;
    load_set(600);
    for (int i = 0; i < 2 * N; i++) begin
      i_enable = (i % 2 == 0);
      @(posedge i_clock);
      @(negedge i_clock);
      chk("toggle_valid", 72'(o_valid), 72'(i_enable));
    end
    chk("toggle_sb", 72'(sb.size()), 72'(0));
    i_enable = 1'b1;
    @(posedge i_clock); #1;
    load_set(700);
    repeat (9) @(negedge i_clock);
    chk("mid_lane7", 72'(o_lane_idx), 72'(7));
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("mid_rst_valid", 72'(o_valid), 72'(0));
    chk("mid_rst_ready", 72'(o_ready), 72'(1));
    chk("mid_rst_ovf", 72'(o_overflow), 72'(0));
    sb.delete();
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    load_set(800);
    wait_drain("restart_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
